// File: rtl/hls_deadlock_reporter_pkg.sv
// hls_deadlock_reporter_pkg: shared FSM state type and widths for the deadlock reporter.
package hls_deadlock_reporter_pkg;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {WATCH, REPORT, HOLD} state_t;
endpackage

// File: rtl/hls_deadlock_reporter_if.sv
// hls_deadlock_reporter_if: valid/ready report channel carrying monitor index and timestamp.
interface hls_deadlock_reporter_if
    import hls_deadlock_reporter_pkg::*;
#(
    parameter int TS_W = 32
);
    logic             report_valid;
    logic             report_ready;
    logic [IDX_W-1:0] report_idx;
    logic [TS_W-1:0]  report_ts;
    modport master (output report_valid, report_idx, report_ts, input report_ready);
    modport slave  (input report_valid, report_idx, report_ts, output report_ready);
endinterface

// File: rtl/hls_deadlock_persist_cnt.sv
// hls_deadlock_persist_cnt: saturating persistence counter with freeze/clear; hit flags the next value at PERSIST.
module hls_deadlock_persist_cnt
    import hls_deadlock_reporter_pkg::*;
#(
    parameter int PERSIST = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic block,
    input  logic freeze,
    input  logic clear,
    output logic hit
);
    logic [CNT_W-1:0] cnt, cnt_next;

    always_comb
        cnt_next = clear  ? '0 :
                   freeze ? cnt :
                   !block ? '0 :
                   cnt == CNT_W'(PERSIST) ? cnt : cnt + 1'b1;

    // Looking at the next value lets the report appear in the same cycle the count lands on PERSIST.
    assign hit = cnt_next == CNT_W'(PERSIST);

    always_ff @(posedge clock)
        cnt <= reset ? '0 : cnt_next;
endmodule

// File: rtl/hls_deadlock_reporter.sv
// hls_deadlock_reporter: watches per-monitor block flags and reports the first persistent deadlock.
module hls_deadlock_reporter
    import hls_deadlock_reporter_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int PERSIST = 16,
    parameter int TS_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               deadlock,
    hls_deadlock_reporter_if.master rpt
);
    state_t           state, state_next;
    logic [NUM_MON-1:0] hit;
    logic [IDX_W-1:0] ridx, ridx_next, low_idx;
    logic [TS_W-1:0]  ts, rts, rts_next;
    logic             clr, frz;

    // A pending report is never dropped, so clear only acts outside REPORT.
    assign clr = clear && state != REPORT;
    assign frz = state == HOLD;

    for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
        hls_deadlock_persist_cnt #(.PERSIST(PERSIST)) u_cnt (
            .clock (clock),
            .reset (reset),
            .block (block_in[i]),
            .freeze(frz),
            .clear (clr),
            .hit   (hit[i])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--)
            low_idx = hit[i] ? IDX_W'(i) : low_idx;
    end

    always_comb begin
        state_next = state;
        ridx_next  = ridx;
        rts_next   = rts;
        case (state)
            WATCH: if (|hit) begin
                state_next = REPORT;
                ridx_next  = low_idx;
                rts_next   = ts + 1'b1;
            end
            REPORT: state_next = rpt.report_ready ? HOLD : REPORT;
            HOLD:   state_next = clear ? WATCH : HOLD;
            default: state_next = WATCH;
        endcase
    end

    always_ff @(posedge clock)
        if (reset) begin
            state <= WATCH;
            ridx  <= '0;
            rts   <= '0;
            ts    <= '0;
        end else begin
            state <= state_next;
            ridx  <= ridx_next;
            rts   <= rts_next;
            ts    <= ts + 1'b1;
        end

    assign deadlock         = state != WATCH;
    assign rpt.report_valid = state == REPORT;
    assign rpt.report_idx   = ridx;
    assign rpt.report_ts    = rts;
endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// tb_hls_deadlock_reporter: directed checks of detection latency, priority, clear handling and reset.
module tb_hls_deadlock_reporter;
    import hls_deadlock_reporter_pkg::*;

    logic       clock = 0;
    logic       reset;
    logic [3:0] block_in;
    logic       clear;
    logic       deadlock;
    int         passed = 0, total = 0, cyc = 0, rr = 0, c0 = 0;

    hls_deadlock_reporter_if #(.TS_W(32)) rpt ();

    hls_deadlock_reporter #(.NUM_MON(4), .PERSIST(16), .TS_W(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .block_in(block_in),
        .clear   (clear),
        .deadlock(deadlock),
        .rpt     (rpt.master)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    initial begin
        reset = 1; block_in = 0; clear = 0; rpt.report_ready = 0;
        tick(2);
        chk("rst_valid", rpt.report_valid, 0);
        chk("rst_idx", rpt.report_idx, 0);
        chk("rst_ts", rpt.report_ts, 0);
        chk("rst_dead", deadlock, 0);
        chk("rst_state", dut.state, WATCH);
        reset = 0; cyc = 0;

        // block_in[2] from cycle 10: report at cycle 26
        tick(10);
        block_in = 4'b0100;
        tick(15);
        chk("a_valid25", rpt.report_valid, 0);
        chk("a_dead25", deadlock, 0);
        tick(1);
        chk("a_valid26", rpt.report_valid, 1);
        chk("a_idx", rpt.report_idx, 2);
        chk("a_ts", rpt.report_ts, 26);
        chk("a_dead26", deadlock, 1);
        rpt.report_ready = 1;
        tick(1);
        rpt.report_ready = 0;
        chk("a_hold_valid", rpt.report_valid, 0);
        chk("a_hold_dead", deadlock, 1);
        chk("a_hold_state", dut.state, HOLD);

        // HOLD: frozen while block_in[1] high, then clear re-arms
        block_in = 4'b0010;
        tick(20);
        chk("e_hold_valid", rpt.report_valid, 0);
        c0 = cyc;
        clear = 1;
        tick(1);
        clear = 0;
        chk("e_watch_dead", deadlock, 0);
        tick(15);
        chk("e_valid_pre", rpt.report_valid, 0);
        tick(1);
        chk("e_valid", rpt.report_valid, 1);
        chk("e_idx", rpt.report_idx, 1);
        chk("e_ts", rpt.report_ts, 64'(c0 + 17));

        // REPORT held 20 cycles with clear at cycle 5: nothing dropped
        rr = cyc;
        for (int k = 0; k < 20; k++) begin
            clear = (k == 5);
            chk("d_valid", rpt.report_valid, 1);
            chk("d_ts", rpt.report_ts, 64'(rr));
            tick(1);
        end
        clear = 0;
        chk("d_valid_end", rpt.report_valid, 1);
        chk("d_idx_end", rpt.report_idx, 1);
        rpt.report_ready = 1;
        tick(1);
        rpt.report_ready = 0;
        chk("d_hold_state", dut.state, HOLD);
        chk("d_hold_valid", rpt.report_valid, 0);

        // block_in[1]: 15 high, 1 low, 16 high
        block_in = 0; clear = 1;
        tick(1);
        clear = 0;
        block_in = 4'b0010;
        tick(15);
        block_in = 0;
        tick(1);
        chk("b_valid_gap", rpt.report_valid, 0);
        block_in = 4'b0010;
        tick(15);
        chk("b_valid_pre", rpt.report_valid, 0);
        tick(1);
        chk("b_valid", rpt.report_valid, 1);
        chk("b_idx", rpt.report_idx, 1);
        chk("b_ts", rpt.report_ts, 64'(cyc));
        rpt.report_ready = 1;
        tick(1);
        rpt.report_ready = 0;
        block_in = 0; clear = 1;
        tick(1);
        clear = 0;

        // monitors 3 and 0 together: lowest index wins
        block_in = 4'b1001;
        tick(16);
        chk("c_valid", rpt.report_valid, 1);
        chk("c_idx", rpt.report_idx, 0);

        // reset mid-handshake beats ready and clear
        reset = 1; rpt.report_ready = 1; clear = 1;
        tick(1);
        chk("r_valid", rpt.report_valid, 0);
        chk("r_idx", rpt.report_idx, 0);
        chk("r_ts", rpt.report_ts, 0);
        chk("r_dead", deadlock, 0);
        chk("r_state", dut.state, WATCH);
        reset = 0; rpt.report_ready = 0; clear = 0; cyc = 0;

        // clear in WATCH restarts the count; timestamp restarted from 0
        block_in = 4'b0001;
        tick(10);
        clear = 1;
        tick(1);
        clear = 0;
        tick(15);
        chk("w_valid_pre", rpt.report_valid, 0);
        tick(1);
        chk("w_valid", rpt.report_valid, 1);
        chk("w_idx", rpt.report_idx, 0);
        chk("w_ts", rpt.report_ts, 27);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hls_deadlock_reporter.md
HLS_DEADLOCK_REPORTER -- requirements
Module: hls_deadlock_reporter

Interface
REQ-001 The block SHALL have parameter NUM_MON, default 4, giving the number of deadlock-monitor block inputs (1..16).
REQ-002 The block SHALL have parameter PERSIST, default 16, giving the consecutive asserted cycles needed to declare deadlock (2..255).
REQ-003 The block SHALL have parameter TS_W, default 32, giving the timestamp width.
REQ-004 The block SHALL have port clock, input, 1, the clock; reset is reset, synchronous, active-high; clock is clock.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port block_in, input, NUM_MON, per-monitor registered block flags.
REQ-007 The block SHALL have port clear, input, 1, a one-cycle pulse that re-arms detection.
REQ-008 The block SHALL have port report_valid, output, 1, report available.
REQ-009 The block SHALL have port report_ready, input, 1, report consumed.
REQ-010 The block SHALL have port report_idx, output, 4, index of the deadlocked monitor.
REQ-011 The block SHALL have port report_ts, output, TS_W, cycle-counter value at detection.
REQ-012 The block SHALL have port deadlock, output, 1, sticky deadlock indication.

Function
REQ-013 The block SHALL keep one 8-bit persistence counter per monitor: +1 while block_in[i]=1 (saturating at PERSIST), 0 in the cycle block_in[i]=0.
REQ-014 The block SHALL run a free-running TS_W-bit cycle counter from 0 after reset, wrapping modulo 2^TS_W.
REQ-015 The block SHALL use a three-state FSM: WATCH, REPORT, HOLD.
REQ-016 In WATCH, the first cycle any counter reaches PERSIST SHALL latch the lowest such index and the current timestamp, and the next state SHALL be REPORT.
REQ-017 In REPORT, report_valid SHALL be 1 and report_idx/report_ts SHALL stay stable until report_valid&report_ready; then the next state SHALL be HOLD.
REQ-018 deadlock SHALL be 1 in REPORT and HOLD and 0 in WATCH.
REQ-019 In HOLD, persistence counters SHALL be frozen and further detections ignored.
REQ-020 clear in HOLD SHALL zero all persistence counters, and the next state SHALL be WATCH.
REQ-021 clear in WATCH SHALL zero all counters.
REQ-022 clear in REPORT SHALL be ignored; the report is never dropped.
REQ-023 Detection latency SHALL be exactly PERSIST cycles from the first sampled block_in[i]=1 to report_valid=1.
REQ-024 A deassertion of block_in[i] for one cycle before PERSIST SHALL restart the count for that monitor only.
REQ-025 When several monitors reach PERSIST in the same cycle, the lowest index SHALL be reported.
REQ-026 report_idx SHALL be zero-extended when NUM_MON<16.

Reset
REQ-027 Reset SHALL force: FSM=WATCH, report_valid=0, report_idx=0, report_ts=0, deadlock=0, all persistence counters=0, cycle counter=0.
REQ-028 Reset asserted in any state, including mid-handshake in REPORT, SHALL take priority over report_ready and clear, and SHALL drop report_valid the next cycle.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the constants IDX_W=4 and CNT_W=8.
REQ-030 One sub-module, hls_deadlock_persist_cnt (a single saturating persistence counter with freeze/clear), SHALL be instantiated NUM_MON times.

Verification
REQ-031 Scenario: block_in[2]=1 held from cycle 10 -> report_valid=1 at cycle 26, report_idx=2, report_ts=26, deadlock=1.
REQ-032 Scenario: block_in[1] high 15 cycles, low 1, high 16 -> exactly one report, idx=1, 16 cycles after re-assertion.
REQ-033 Scenario: block_in[3] and block_in[0] rise in the same cycle -> report_idx=0.
REQ-034 Scenario: report_ready=0 for 20 cycles with clear pulsed at cycle 5 of REPORT -> report_valid stays 1, fields stable, handshake completes, then HOLD.
REQ-035 Scenario: HOLD, clear pulse, block_in[1] still high -> new report of idx=1 exactly 16 cycles after clear.
REQ-036 Scenario: reset asserted while report_valid=1 -> next cycle all outputs 0 and FSM=WATCH.
